// File: rtl/ahb_apb_bridge_pkg.sv
// ahb_apb_bridge_pkg: shared state encoding, AHB constants and the APB4 byte-strobe helper.
package ahb_apb_bridge_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERR1, ERR2} state_e;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    function automatic logic [3:0] byte_strb(input logic [2:0] size, input logic [1:0] addr);
        return size == 3'd0 ? 4'b0001 << addr : size == 3'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/ahb_apb_bridge_mc_timeout.sv
// apb_timeout_cnt: counts ACCESS cycles and flags the last one allowed; constant 0 when TIMEOUT_CYCLES=0.
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    if (TIMEOUT_CYCLES == 0) begin : g_off
        logic unused_in;
        assign unused_in = &{1'b0, clk, rst, clr, en};
        assign expired = 1'b0;
    end else begin : g_on
        localparam int W = $clog2(TIMEOUT_CYCLES + 1);
        logic [W-1:0] cnt_q, cnt_d;
        always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
        always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
        assign expired = en && cnt_q == W'(TIMEOUT_CYCLES - 1);
    end
endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// ahb_apb_bridge_mc: AHB-Lite slave to APB3 master bridge, all outputs registered.
// Define AHB_APB_BRIDGE_APB4_EN to add the APB4 PPROT/PSTRB outputs.
module ahb_apb_bridge_mc
    import ahb_apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 16,
    parameter int SLOT_BITS      = 24,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADYIN,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
`ifdef AHB_APB_BRIDGE_APB4_EN
    ,
    output logic [2:0]              PPROT,
    output logic [DATA_WIDTH/8-1:0] PSTRB
`endif
);
    state_e                state_q, state_d;
    logic                  hreadyout_q, hreadyout_d, hresp_q, hresp_d;
    logic                  pwrite_q, pwrite_d, penable_q, penable_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d, pwdata_q, pwdata_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic [3:0]            slot;
    logic                  accept, slot_ok, expired, unused_in;
`ifdef AHB_APB_BRIDGE_APB4_EN
    logic [2:0]              pprot_q, pprot_d;
    logic [DATA_WIDTH/8-1:0] pstrb_q, pstrb_d;
    assign unused_in = HTRANS[0];
`else
    assign unused_in = &{1'b0, HTRANS[0], HSIZE, HPROT};
`endif
    assign slot    = HADDR[SLOT_BITS+3:SLOT_BITS];
    assign slot_ok = {1'b0, slot} < 5'(NUM_SLAVES);
    assign accept  = HSEL && HREADYIN && HTRANS[1];
    apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk     (HCLK),
        .rst     (HRESET),
        .clr     (state_q != ACCESS),
        .en      (state_q == ACCESS),
        .expired (expired)
    );
    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
`ifdef AHB_APB_BRIDGE_APB4_EN
        pprot_d     = pprot_q;
        pstrb_d     = pstrb_q;
`endif
        case (state_q)
            IDLE, DONE, ERR2: begin
                if (accept) begin
                    paddr_d     = HADDR;
                    pwrite_d    = HWRITE;
                    hreadyout_d = 1'b0;
                    state_d     = slot_ok ? SETUP : ERR1;
                    hresp_d     = slot_ok ? HRESP_OKAY : HRESP_ERROR;
                    psel_d      = slot_ok ? NUM_SLAVES'(1) << slot : '0;
`ifdef AHB_APB_BRIDGE_APB4_EN
                    pprot_d     = slot_ok ? {~HPROT[0], 1'b0, HPROT[1]} : pprot_q;
                    pstrb_d     = slot_ok ? (HWRITE ? byte_strb(HSIZE, HADDR[1:0]) : '1) : pstrb_q;
`endif
                end else begin
                    state_d     = IDLE;
                    hreadyout_d = 1'b1;
                    hresp_d     = HRESP_OKAY;
`ifdef AHB_APB_BRIDGE_APB4_EN
                    pprot_d     = '0;
                    pstrb_d     = '0;
`endif
                end
            end
            SETUP: begin
                pwdata_d  = HWDATA;
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PSLVERR only counts on the PREADY cycle; a timeout ends the access as an error
                if (PREADY || expired) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (PREADY && !PSLVERR) begin
                        state_d     = DONE;
                        hreadyout_d = 1'b1;
                        hrdata_d    = pwrite_q ? hrdata_q : PRDATA;
                    end else begin
                        state_d = ERR1;
                        hresp_d = HRESP_ERROR;
                    end
                end
            end
            ERR1: begin
                state_d     = ERR2;
                hreadyout_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
`ifdef AHB_APB_BRIDGE_APB4_EN
            pprot_q     <= '0;
            pstrb_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
`ifdef AHB_APB_BRIDGE_APB4_EN
            pprot_q     <= pprot_d;
            pstrb_q     <= pstrb_d;
`endif
        end
    end
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
`ifdef AHB_APB_BRIDGE_APB4_EN
    assign PPROT     = pprot_q;
    assign PSTRB     = pstrb_q;
`endif
endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// tb_ahb_apb_bridge_mc: directed transfers against a transaction-timeline model of the bridge.
module tb_ahb_apb_bridge_mc;
    localparam int TMO = 8;
    logic clk = 1'b0;
    logic HRESET, HSEL, HWRITE, HREADYIN, PREADY, PSLVERR;
    logic [31:0] HADDR, HWDATA, PRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic d_hready, d_hresp, d_pwrite, d_pen, e_hready, e_hresp, e_pwrite, e_pen;
    logic [31:0] d_hrdata, d_paddr, d_pwdata, e_hrdata, e_paddr, e_pwdata;
    logic [15:0] d_psel;
    logic [3:0]  e_psel;
    logic a_hready, a_hresp, a_pwrite, a_pen;
    logic [31:0] a_hrdata, a_paddr, a_pwdata;
    logic [15:0] a_psel;
    logic sel, chk_on;
    int ns, vecs, miss, wrun, prun, last_wait, last_pen, li;
    logic [15:0] psel_seen;
    logic exp_hready, exp_hresp, exp_pen, m_pwrite;
    logic [15:0] exp_psel;
    logic [31:0] m_paddr, m_pwdata, m_hrdata;
    string ln[$];
    logic [63:0] la[$], le[$];
    always #5 clk = ~clk;
    ahb_apb_bridge_mc #(.NUM_SLAVES(16), .TIMEOUT_CYCLES(TMO)) dut (
        .HCLK(clk), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(d_hready),
        .HRESP(d_hresp), .HRDATA(d_hrdata), .PSEL(d_psel), .PADDR(d_paddr), .PWRITE(d_pwrite),
        .PENABLE(d_pen), .PWDATA(d_pwdata), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));
    ahb_apb_bridge_mc #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(TMO)) dut4 (
        .HCLK(clk), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(e_hready),
        .HRESP(e_hresp), .HRDATA(e_hrdata), .PSEL(e_psel), .PADDR(e_paddr), .PWRITE(e_pwrite),
        .PENABLE(e_pen), .PWDATA(e_pwdata), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));
    assign a_hready = sel ? e_hready : d_hready;
    assign a_hresp  = sel ? e_hresp : d_hresp;
    assign a_pwrite = sel ? e_pwrite : d_pwrite;
    assign a_pen    = sel ? e_pen : d_pen;
    assign a_hrdata = sel ? e_hrdata : d_hrdata;
    assign a_paddr  = sel ? e_paddr : d_paddr;
    assign a_pwdata = sel ? e_pwdata : d_pwdata;
    assign a_psel   = sel ? {12'b0, e_psel} : d_psel;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vecs++;
        if (a !== e) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
        end
    endtask
    always @(negedge clk) begin
        if (chk_on) begin
            chk("HREADYOUT", 64'(a_hready), 64'(exp_hready));
            chk("HRESP", 64'(a_hresp), 64'(exp_hresp));
            chk("PSEL", 64'(a_psel), 64'(exp_psel));
            chk("PENABLE", 64'(a_pen), 64'(exp_pen));
            chk("PADDR", 64'(a_paddr), 64'(m_paddr));
            chk("PWRITE", 64'(a_pwrite), 64'(m_pwrite));
            chk("PWDATA", 64'(a_pwdata), 64'(m_pwdata));
            chk("HRDATA", 64'(a_hrdata), 64'(m_hrdata));
        end
        while (li < ln.size()) begin
            chk(ln[li], la[li], le[li]);
            li++;
        end
    end
    task automatic lit(input string n, input logic [63:0] a, input logic [63:0] e);
        ln.push_back(n);
        la.push_back(a);
        le.push_back(e);
    endtask
    task automatic set_exp(input logic r, input logic e, input logic [15:0] s, input logic p);
        exp_hready = r;
        exp_hresp  = e;
        exp_psel   = s;
        exp_pen    = p;
    endtask
    // advance one clock and record HREADYOUT-low and PENABLE-high run lengths
    task automatic cyc();
        @(posedge clk);
        #1;
        psel_seen |= a_psel;
        if (!a_hready) wrun++;
        else begin
            if (wrun != 0) last_wait = wrun;
            wrun = 0;
        end
        if (a_pen) prun++;
        else begin
            if (prun != 0) last_pen = prun;
            prun = 0;
        end
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            set_exp(1'b1, 1'b0, 16'h0, 1'b0);
        end
    endtask
    // one transfer: address now, then SETUP, ACCESS with nwait PREADY-low cycles, then DONE or ERR1/ERR2
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd, input int nwait,
                        input logic err, input logic [31:0] rd);
        int slot;
        logic fail;
        slot = int'(a[27:24]);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w;
        cyc();
        HSEL = 1'b0; HTRANS = 2'b00;
        m_paddr = a; m_pwrite = w;
        if (slot >= ns) begin
            set_exp(1'b0, 1'b1, 16'h0, 1'b0);
            cyc();
            set_exp(1'b1, 1'b1, 16'h0, 1'b0);
            return;
        end
        set_exp(1'b0, 1'b0, 16'h1 << slot, 1'b0);
        HWDATA = wd;
        cyc();
        m_pwdata = wd;
        fail = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            set_exp(1'b0, 1'b0, 16'h1 << slot, 1'b1);
            PREADY = (i == nwait);
            PSLVERR = (i == nwait) ? err : 1'b1;
            PRDATA = rd;
            cyc();
            if (i == nwait) begin
                fail = err;
                break;
            end
            if (i == TMO - 1) begin
                fail = 1'b1;
                break;
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        if (fail) begin
            set_exp(1'b0, 1'b1, 16'h0, 1'b0);
            cyc();
            set_exp(1'b1, 1'b1, 16'h0, 1'b0);
        end else begin
            if (!w) m_hrdata = rd;
            set_exp(1'b1, 1'b0, 16'h0, 1'b0);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        vecs = 0; miss = 0; wrun = 0; prun = 0; last_wait = 0; last_pen = 0; li = 0;
        sel = 1'b0; ns = 16; chk_on = 1'b0; psel_seen = '0;
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010;
        HPROT = 4'b0011; HWDATA = '0; HREADYIN = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0;
        set_exp(1'b1, 1'b0, 16'h0, 1'b0);
        cyc();
        cyc();
        chk_on = 1'b1;
        HRESET = 1'b0;
        lit("rst_hready", 64'(a_hready), 64'd1);
        lit("rst_psel", 64'(a_psel), 64'd0);
        idle(2);
        HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h0100_0000;
        cyc();
        set_exp(1'b1, 1'b0, 16'h0, 1'b0);
        HTRANS = 2'b10; HREADYIN = 1'b0;
        cyc();
        set_exp(1'b1, 1'b0, 16'h0, 1'b0);
        HSEL = 1'b0; HTRANS = 2'b00; HREADYIN = 1'b1;
        idle(2);
        psel_seen = '0;
        xfer(32'h0100_0004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
        lit("wr_psel", 64'(psel_seen), 64'h0002);
        lit("wr_paddr", 64'(a_paddr), 64'h0100_0004);
        lit("wr_pwdata", 64'(a_pwdata), 64'hDEAD_BEEF);
        lit("wr_wait", 64'(last_wait), 64'd2);
        lit("wr_hresp", 64'(a_hresp), 64'd0);
        idle(2);
        xfer(32'h0300_0010, 1'b0, 32'h0, 5, 1'b0, 32'h1234_5678);
        lit("rd_wait", 64'(last_wait), 64'd7);
        lit("rd_hrdata", 64'(a_hrdata), 64'h1234_5678);
        lit("rd_hresp", 64'(a_hresp), 64'd0);
        idle(2);
        xfer(32'h0200_0000, 1'b1, 32'hA5A5_0001, 0, 1'b1, 32'h0);
        lit("err_hresp", 64'(a_hresp), 64'd1);
        lit("err_hready", 64'(a_hready), 64'd1);
        lit("err_wait", 64'(last_wait), 64'd3);
        idle(2);
        psel_seen = '0;
        xfer(32'h0000_0020, 1'b0, 32'h0, 100, 1'b0, 32'hFFFF_FFFF);
        lit("tmo_pen", 64'(last_pen), 64'd8);
        lit("tmo_psel", 64'(psel_seen), 64'h0001);
        lit("tmo_wait", 64'(last_wait), 64'd10);
        lit("tmo_hrdata", 64'(a_hrdata), 64'h1234_5678);
        idle(2);
        lit("tmo_idle", 64'(a_hresp), 64'd0);
        xfer(32'h0100_0008, 1'b1, 32'h0BAD_CAFE, 0, 1'b0, 32'h0);
        xfer(32'h0200_000C, 1'b0, 32'h0BAD_CAFE, 0, 1'b0, 32'hCAFE_F00D);
        lit("b2b_wait", 64'(last_wait), 64'd2);
        lit("b2b_hrdata", 64'(a_hrdata), 64'hCAFE_F00D);
        idle(1);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0100_0000; HWRITE = 1'b1;
        cyc();
        HSEL = 1'b0; HTRANS = 2'b00; m_paddr = 32'h0100_0000; m_pwrite = 1'b1;
        set_exp(1'b0, 1'b0, 16'h0002, 1'b0);
        HWDATA = 32'h5555_AAAA;
        cyc();
        m_pwdata = 32'h5555_AAAA;
        set_exp(1'b0, 1'b0, 16'h0002, 1'b1);
        HRESET = 1'b1;
        cyc();
        HRESET = 1'b0;
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0;
        set_exp(1'b1, 1'b0, 16'h0, 1'b0);
        lit("rst2_psel", 64'(a_psel), 64'd0);
        lit("rst2_pen", 64'(a_pen), 64'd0);
        lit("rst2_hready", 64'(a_hready), 64'd1);
        lit("rst2_hrdata", 64'(a_hrdata), 64'd0);
        idle(2);
        sel = 1'b1; ns = 4; psel_seen = '0;
        xfer(32'h0900_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        lit("ns4_psel", 64'(psel_seen), 64'd0);
        lit("ns4_hresp", 64'(a_hresp), 64'd1);
        lit("ns4_wait", 64'(last_wait), 64'd1);
        idle(3);
        xfer(32'h0300_0000, 1'b1, 32'h0000_0001, 0, 1'b0, 32'h0);
        lit("ns4_ok", 64'(a_hresp), 64'd0);
        idle(2);
        chk_on = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/ahb_apb_bridge_mc.md
Name: ahb_apb_bridge_mc

Overview:
- Parametrised AHB-Lite slave to APB3 master bridge with NUM_SLAVES one-hot PSEL decode, PREADY wait states, PSLVERR mapping and an access timeout.
- Successor to the fixed 16-slot bridge used behind the BFM.
- Sits between the AHB fabric, or the BFM master, and the APB peripheral bus (GPIO, UART, timers).

Parameters:
- ADDR_WIDTH, 32, HADDR/PADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA/PWDATA/PRDATA width; 32 only in this revision.
- NUM_SLAVES, 16, number of APB slots, 1..16.
- SLOT_BITS, 24, slot index is HADDR[SLOT_BITS+3:SLOT_BITS]; requires SLOT_BITS+4 <= ADDR_WIDTH.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles with PREADY low before an error is forced; 0 disables the timeout.

Ports:
- HCLK  in  1  single clock for AHB and APB sides.
- HRESET  in  1  synchronous reset, active-high.
- HSEL  in  1  bridge selected.
- HADDR  in  ADDR_WIDTH  AHB address.
- HTRANS  in  2  AHB transfer type.
- HWRITE  in  1  write/read.
- HSIZE  in  3  transfer size.
- HPROT  in  4  protection attributes.
- HWDATA  in  DATA_WIDTH  write data.
- HREADYIN  in  1  bus HREADY.
- HREADYOUT  out  1  bridge ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_WIDTH  read data.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PADDR  out  ADDR_WIDTH  APB address, full HADDR.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB access phase.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  data from the selected slave, already muxed.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Clock and reset: one clock HCLK; reset HRESET is synchronous and active-high.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, state IDLE, timeout counter 0.
- All outputs are registered.
- Acceptance:
  - An address phase is accepted when HSEL & HREADYIN & HTRANS[1] and the state is IDLE, DONE or ERR2.
  - On acceptance, HADDR, HWRITE, HSIZE and HPROT are latched.
  - HTRANS IDLE or BUSY gives a zero-wait OKAY and no APB activity.
- State IDLE: HREADYOUT=1. An accepted transfer goes to SETUP if slot < NUM_SLAVES, otherwise to ERR1 with no APB access.
- State SETUP: one cycle. PSEL[slot]=1, PENABLE=0, HREADYOUT=0, PWDATA=HWDATA sampled in this data-phase cycle. Next state is ACCESS.
- State ACCESS:
  - PENABLE=1, HREADYOUT=0, timeout counter increments each cycle.
  - PREADY & !PSLVERR: capture PRDATA into HRDATA (reads only; writes leave HRDATA unchanged), drop PSEL and PENABLE, go to DONE.
  - PREADY & PSLVERR: drop PSEL and PENABLE, go to ERR1.
  - PREADY low and counter = TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0): drop PSEL and PENABLE, go to ERR1.
  - PSLVERR is ignored whenever PREADY=0.
- State DONE: HREADYOUT=1, HRESP=0. A back-to-back accepted transfer goes directly to SETUP or ERR1; otherwise go to IDLE.
- State ERR1: HREADYOUT=0, HRESP=1. Next state is ERR2.
- State ERR2: HREADYOUT=1, HRESP=1. Next transfer is accepted as in DONE; otherwise go to IDLE.
- Minimum latency: address phase at cycle N, SETUP at N+1, ACCESS at N+2, DONE (HREADYOUT=1) at N+3, i.e. 2 wait states.
- Each PREADY-low cycle adds one wait state.
- HRESET asserted mid-transfer: all outputs return to reset values on the next edge, with no completion pulse and PSEL dropped immediately.
- Slot decode: slot = HADDR[SLOT_BITS+3:SLOT_BITS]. With NUM_SLAVES=16 every address decodes to a valid slot.

Optional Feature:
- Macro: AHB_APB_BRIDGE_APB4_EN.
- Defined:
  - Adds outputs PPROT[2:0] and PSTRB[DATA_WIDTH/8-1:0], both registered in SETUP and cleared in IDLE.
  - PPROT = {~HPROT[0], 1'b0, HPROT[1]}.
  - PSTRB is all-ones for reads per APB4, or the HSIZE/HADDR[1:0] byte mask for writes; e.g. byte at offset 2 gives 4'b0100.
- Undefined: ports are absent and behaviour is otherwise identical.

Decomposition:
- Package ahb_apb_bridge_pkg holds:
  - state encoding: IDLE, SETUP, ACCESS, DONE, ERR1, ERR2;
  - HTRANS encodings and HRESP_OKAY/HRESP_ERROR constants;
  - the byte-strobe function.
- Sub-module apb_timeout_cnt: clear/enable/expire counter, width $clog2(TIMEOUT_CYCLES+1), tied off when TIMEOUT_CYCLES=0.

Test Plan:
- Write 0x0100_0004 data 0xDEADBEEF, PREADY=1 -> PSEL=16'h0002, PADDR=0x0100_0004, PWDATA=0xDEADBEEF, HREADYOUT high at N+3, HRESP=0.
- Read slot 3 with PREADY low 5 cycles, PRDATA=0x12345678 -> 7 wait states, HRDATA=0x12345678, OKAY.
- PSLVERR=1 with PREADY=1 -> ERR1 then ERR2; HRESP=1 on both cycles, HREADYOUT 0 then 1.
- NUM_SLAVES=4, access slot 9 -> no PSEL bit asserted, two-cycle ERROR response.
- TIMEOUT_CYCLES=8, PREADY held low -> PSEL drops after 8 ACCESS cycles, ERROR response, bridge returns to IDLE.
- Back-to-back write then read accepted in DONE, plus HRESET asserted during ACCESS -> second SETUP follows DONE directly; reset clears PSEL and PENABLE next edge and HREADYOUT=1.
